des_decryption_unroll4: RTL and testbench
=========================================

// Module: des_decryption_unroll4
// PURPOSE
//   DES decryption core, the inverse of the 4-round-unrolled DES encryption core.
//   Takes a 64-bit ciphertext and the 16 pre-expanded 48-bit round keys.
//   Applies the keys in reverse order (K16..K1), UNROLL Feistel rounds per clock.
//   Returns the 64-bit plaintext with a one-cycle done pulse.
//   Sits beside the encryption core and uses the same key-schedule output format.
// PARAMETERS
//   UNROLL  4  Feistel rounds evaluated per clock; legal values 1,2,4,8,16 (divides 16)
// PORTS
//   clk         input   1    system clock, rising edge
//   rst_n       input   1    asynchronous active-low reset
//   start       input   1    one-cycle request; samples message and round_keys
//   message     input   64   [1:64] ciphertext, bit 1 = DES bit 1 (MSB)
//   round_keys  input   768  [1:768] K1 at [1:48] ... K16 at [721:768] (encryption order)
//   done        output  1    one-cycle pulse; result valid from this cycle
//   result      output  64   [1:64] plaintext
// BEHAVIOUR
//   Reset: async on rst_n low; state=IDLE, round counter=0, done=0, result=64'h0, L/R regs=0.
//   FSM IDLE -> ROUND -> FINISH -> IDLE.
//   - IDLE: start=1 at edge E0:
//     - capture IP(message) into L0/R0 (L=bits 1:32, R=bits 33:64).
//     - clear the round counter; go to ROUND.
//   - ROUND: each edge applies UNROLL rounds; in-cycle round i uses K(17-i).
//     - f = P(S(E(R) ^ K)); L'=R; R'=L ^ f.
//     - counter advances by UNROLL; after 16 rounds go to FINISH.
//   - FINISH: one edge loads result = FP({R16,L16}) (swap then IP^-1).
//     - done=1 for exactly the next cycle; return to IDLE.
//   Latency: start sampled at E0 -> done=1 in the cycle after edge E0+16/UNROLL+1.
//     For UNROLL=4, done is high in the 6th cycle.
//   result holds its value until the FINISH edge of the next operation; it is not cleared by start.
//   start while in ROUND or FINISH: ignored, with no effect on the in-flight operation.
//   start in the cycle done=1 (FSM in IDLE): accepted; back-to-back throughput of one block per 16/UNROLL+2 cycles.
//   Reset mid-operation: operation aborted, no done pulse, outputs return to reset values.
//   The in-flight message/key values are not reused after reset.
//   All arithmetic is bitwise XOR/permutation; no carries. S-box index uses the DES row/column rule:
//     row = bits 1,6; column = bits 2..5 of each 6-bit group.
// CONFIGURATION
//   DES_DEC_KEY_LATCH_EN defined:
//     - round_keys captured into an internal 768-bit register at the start edge.
//     - Input may change any time after that edge.
//   DES_DEC_KEY_LATCH_EN undefined:
//     - no key register; round_keys read directly each ROUND cycle.
//     - Must stay stable from start until done; if it changes, result is undefined.
//   Ports, latency and done timing are identical in both builds.
// TESTING
//   1. All-zero keys (round_keys=768'h0), message=64'h8CA64DE9C1B123A7 -> result=64'h0000000000000000, done 1 cycle.
//   2. Schedule of key 133457799BBCDFF1 (K1=48'h1B02EFFC7072 ... K16=48'hCB3D8B0E17F5), message=64'h85E813540F0AB405
//      -> result=64'h0123456789ABCDEF.
//   3. Round-trip: for every line of des_tests.txt (round_keys, plaintext, ciphertext):
//      - feed the ciphertext as message; require result == plaintext.
//      - require done exactly 16/UNROLL+2 cycles after start.
//      - count nb_correct == nb_tests.
//   4. Pulse start again 2 cycles into ROUND with different data -> first result unchanged.
//      - Exactly one done pulse for the first operation.
//   5. Assert start in the done cycle of op A, run op B -> two correct results; B's done 6 cycles after A's (UNROLL=4).
//   6. Drop rst_n for 1 cycle mid-ROUND -> done=0, result=64'h0 immediately.
//      - Next start after release decrypts correctly (vector 1).

Source files
------------

// File: rtl/des_decryption_unroll4.sv
// DES decryption core: IP, sixteen Feistel rounds with keys K16..K1 (UNROLL per clock), swap, FP.
// Build option DES_DEC_KEY_LATCH_EN registers round_keys at the start edge; otherwise they are read live.
module des_decryption_unroll4 #(
    parameter int UNROLL = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [63:0]  message,
    input  logic [767:0] round_keys,
    output logic         done,
    output logic [63:0]  result
);
    // state  | meaning
    // IDLE   | waiting for start; L/R loaded with IP(message) on start
    // ROUND  | UNROLL Feistel rounds per edge, keys taken from K16 downwards
    // FINISH | result <= FP({R16,L16}); done pulses in the following cycle
    typedef enum logic [1:0] {IDLE, ROUND, FINISH} state_t;

    localparam int IP_T [64] = '{58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
                                 62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
                                 57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
                                 61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int FP_T [64] = '{40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
                                 38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
                                 36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
                                 34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
    localparam int E_T [48] = '{32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
                                 8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
                                16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
                                24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int P_T [32] = '{16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
                                 2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    // Each box holds 64 nibbles, entry (row*16 + col) starting at the MSB end.
    localparam logic [0:7][255:0] SBOX = {
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
        return y;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
        return y;
    endfunction

    function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] y;
        logic [5:0]  b;
        logic [5:0]  idx;
        x = '0;
        s = '0;
        y = '0;
        for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
        x = x ^ k;
        for (int g = 0; g < 8; g++) begin
            b   = x[47-6*g -: 6];
            idx = {b[5], b[0], b[4:1]};
            s[31-4*g -: 4] = SBOX[g][255-4*int'(idx) -: 4];
        end
        for (int i = 0; i < 32; i++) y[31-i] = s[32-P_T[i]];
        return y;
    endfunction

    state_t       state_q, state_d;
    logic [4:0]   cnt_q;
    logic [31:0]  l_q, r_q, l_nxt, r_nxt, r_tmp;
    logic [3:0]   kidx;
    logic [767:0] keys;

`ifdef DES_DEC_KEY_LATCH_EN
    logic [767:0] key_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) key_q <= '0;
        else if (state_q == IDLE && start) key_q <= round_keys;
    end

    assign keys = key_q;
`else
    assign keys = round_keys;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ROUND;
            ROUND:   if (cnt_q + 5'(UNROLL) == 5'd16) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // K(16-m) sits at bits [48m+47:48m]; m is the number of rounds already applied.
    always_comb begin
        l_nxt = l_q;
        r_nxt = r_q;
        r_tmp = '0;
        kidx  = '0;
        for (int u = 0; u < UNROLL; u++) begin
            kidx  = cnt_q[3:0] + 4'(u);
            r_tmp = l_nxt ^ feistel(r_nxt, keys[48*kidx +: 48]);
            l_nxt = r_nxt;
            r_nxt = r_tmp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            l_q    <= '0;
            r_q    <= '0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        {l_q, r_q} <= ip_perm(message);
                        cnt_q      <= '0;
                    end
                end
                ROUND: begin
                    l_q   <= l_nxt;
                    r_q   <= r_nxt;
                    cnt_q <= cnt_q + 5'(UNROLL);
                end
                FINISH: begin
                    result <= fp_perm({r_q, l_q});
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_des_decryption_unroll4.sv
// Bench for des_decryption_unroll4: DES reference model with per-cycle done/result comparison,
// directed vectors (zero key, 133457799BBCDFF1 schedule), ignored starts, back-to-back, reset abort.
module tb_des_decryption_unroll4;
    localparam int U   = 4;
    localparam int LAT = 16 / U + 1;

    localparam int IP_T [64] = '{58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
                                 62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
                                 57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
                                 61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int P_T [32] = '{16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
                                 2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    // Row (4*box + row) of the S-boxes, column c at nibble c from the MSB.
    localparam logic [63:0] SROW [32] = '{
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};

    localparam logic [63:0]  V1_MSG = 64'h8CA64DE9C1B123A7;
    localparam logic [63:0]  V2_MSG = 64'h85E813540F0AB405;
    localparam logic [63:0]  V2_PT  = 64'h0123456789ABCDEF;
    localparam logic [767:0] K_V2 = {
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [63:0]  message = '0;
    logic [767:0] round_keys = '0;
    logic         done;
    logic [63:0]  result;

    int n_vec = 0;
    int n_err = 0;

    des_decryption_unroll4 #(.UNROLL(U)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .message    (message),
        .round_keys (round_keys),
        .done       (done),
        .result     (result)
    );

    always #5 clk = ~clk;

    // ---- reference DES (bit n of a w-bit value is v[w-n]) ----
    function automatic logic [63:0] ip_m(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int n = 1; n <= 64; n++) y[64-n] = x[64-IP_T[n-1]];
        return y;
    endfunction

    // Inverse of IP, derived from the IP table itself.
    function automatic logic [63:0] fp_m(input logic [63:0] y);
        logic [63:0] x;
        x = '0;
        for (int n = 1; n <= 64; n++) x[64-IP_T[n-1]] = y[64-n];
        return x;
    endfunction

    function automatic logic [31:0] f_m(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s, p;
        logic [5:0]  six;
        int src, row, col;
        x = '0; s = '0; p = '0;
        for (int g = 0; g < 8; g++)
            for (int j = 0; j < 6; j++) begin
                src = 4 * g + j;
                if (src == 0)  src = 32;
                if (src == 33) src = 1;
                x[47-(6*g+j)] = r[32-src];
            end
        x = x ^ k;
        for (int g = 0; g < 8; g++) begin
            six = x[47-6*g -: 6];
            row = 2 * int'(six[5]) + int'(six[0]);
            col = int'(six[4:1]);
            s[31-4*g -: 4] = SROW[4*g+row][63-4*col -: 4];
        end
        for (int n = 1; n <= 32; n++) p[32-n] = s[32-P_T[n-1]];
        return p;
    endfunction

    function automatic logic [47:0] subkey(input logic [767:0] rk, input int n);
        return rk[768-48*n +: 48];
    endfunction

    function automatic logic [63:0] des_model(input logic [63:0] blk, input logic [767:0] rk,
                                              input bit decrypt);
        logic [63:0] t64;
        logic [31:0] l, r, t;
        t64 = ip_m(blk);
        l = t64[63:32];
        r = t64[31:0];
        for (int i = 1; i <= 16; i++) begin
            t = r;
            r = l ^ f_m(r, subkey(rk, decrypt ? 17 - i : i));
            l = t;
        end
        return fp_m({r, l});
    endfunction

    // ---- transaction model: an accepted start occupies the core until its done edge ----
    int          edge_n = 0;
    int          done_edge = -1;
    logic [63:0] pend_res = '0;
    logic [63:0] exp_res = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_edge <= -1;
            pend_res  <= '0;
            exp_res   <= '0;
        end else begin
            edge_n <= edge_n + 1;
            if (edge_n + 1 == done_edge)
                exp_res <= pend_res;
            else if (start && edge_n + 1 > done_edge) begin
                done_edge <= edge_n + 1 + LAT;
                pend_res  <= des_model(message, round_keys, 1'b1);
            end
        end
    end

    logic exp_done;
    always @(negedge clk) begin
        exp_done = (edge_n == done_edge);
        n_vec++;
        if (done !== exp_done) begin
            n_err++;
            $display("FAIL done_cycle edge %0d: got %b want %b", edge_n, done, exp_done);
        end
        n_vec++;
        if (result !== exp_res) begin
            n_err++;
            $display("FAIL result_cycle edge %0d: got %h want %h", edge_n, result, exp_res);
        end
    end

    // ---- stimulus ----
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic issue(input logic [63:0] m, input logic [767:0] k);
        @(negedge clk);
        message    = m;
        round_keys = k;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        if (done !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: done=%b after %0d cycles, want 1", tag, done, cycles);
        end
    endtask

    int           cyc;
    bit           b2b;
    logic [767:0] rk_r;
    logic [63:0]  pt_r, ct_r;

    initial begin
        chk("model_zero_key", des_model(V1_MSG, '0, 1'b1), 64'h0);
        chk("model_v2_dec", des_model(V2_MSG, K_V2, 1'b1), V2_PT);
        chk("model_v2_enc", des_model(V2_PT, K_V2, 1'b0), V2_MSG);

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_done", 64'(done), 64'h0);
        chk("reset_result", result, 64'h0);

        issue(V1_MSG, '0);
        wait_done("v1", cyc);
        chk("v1_result", result, 64'h0);
        chk("v1_latency", 64'(cyc + 1), 64'(16 / U + 2));

        issue(V2_MSG, K_V2);
        wait_done("v2", cyc);
        chk("v2_result", result, V2_PT);

        // second start two cycles into ROUND must be ignored
        issue(V2_MSG, K_V2);
        @(negedge clk);
        message = 64'hFEDCBA9876543210;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignored_start", cyc);
        chk("ignored_start_result", result, V2_PT);
        repeat (8) @(negedge clk);
        chk("ignored_start_hold", result, V2_PT);

        // back-to-back: op B requested in op A's done cycle
        issue(V2_MSG, K_V2);
        wait_done("b2b_a", cyc);
        chk("b2b_a_result", result, V2_PT);
        message    = V1_MSG;
        round_keys = '0;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("b2b_b", cyc);
        chk("b2b_b_result", result, 64'h0);
        chk("b2b_spacing", 64'(cyc + 1), 64'(LAT + 1));

        // reset in the middle of ROUND
        issue(V2_MSG, K_V2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_done", 64'(done), 64'h0);
        chk("abort_result", result, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(V1_MSG, '0);
        wait_done("after_reset_v1", cyc);
        chk("after_reset_v1", result, 64'h0);
        issue(V2_MSG, K_V2);
        wait_done("after_reset_v2", cyc);
        chk("after_reset_v2", result, V2_PT);

        // random round trips with stray starts while busy
        b2b = 1'b0;
        for (int t = 0; t < 40; t++) begin
            for (int w = 0; w < 24; w++) rk_r[32*w +: 32] = $urandom;
            pt_r = {$urandom, $urandom};
            ct_r = des_model(pt_r, rk_r, 1'b0);
            if (!b2b) repeat ($urandom_range(0, 3)) @(negedge clk);
            message    = ct_r;
            round_keys = rk_r;
            start      = 1'b1;
            @(negedge clk);
            start = 1'b0;
            cyc   = 0;
            while (done !== 1'b1 && cyc < 40) begin
                if ($urandom_range(0, 2) == 0) begin
                    start   = 1'b1;
                    message = {$urandom, $urandom};
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
            start = 1'b0;
            if (done !== 1'b1) begin
                n_vec++;
                n_err++;
                $display("FAIL rt_timeout: done=%b after %0d cycles, want 1", done, cyc);
            end
            chk("rt_result", result, pt_r);
            chk("rt_latency", 64'(cyc + 1), 64'(16 / U + 2));
            b2b = ($urandom_range(0, 1) == 1);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
